// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory-port arbiter: FSM state encodings,
// default bus widths and the burst-counter width helper.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_OWN0 = 2'b01,
        ST_OWN1 = 2'b10
    } arb_state_t;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;

    // One spare bit keeps BURST_MAX = 1 from collapsing to a zero-width counter.
    function automatic int burst_cnt_w(input int burst_max);
        return $clog2(burst_max) + 1;
    endfunction

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// Combinational two-way request picker, shared with the I/O port arbiter.
// On contention: fixed mode favours port 0, otherwise the port not served last.
module arb_pick (
    input  logic req0,
    input  logic req1,
    input  logic last,
    input  logic fixed,
    output logic pick,
    output logic valid
);

    assign valid = req0 | req1;
    assign pick  = (req0 && req1) ? (fixed ? 1'b0 : ~last) : req1;

endmodule

// File: rtl/mem_arbiter.sv
// Two-master arbiter for the single memory port: cpu on port 0, loader/DMA on port 1.
// Moore FSM with bounded bursts, output mux and registered read-valid return.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W         = ADDR_W_DEF,
    parameter int DATA_W         = DATA_W_DEF,
    parameter int BURST_MAX      = 16,
    parameter int FIXED_PRIORITY = 0
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              write0,
    input  logic              write1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] to_memory,
    output logic              write,
    input  logic [DATA_W-1:0] from_memory
);

    localparam int               CNT_W    = burst_cnt_w(BURST_MAX);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_MAX - 1);
    localparam logic             FIXED    = (FIXED_PRIORITY != 0);

    arb_state_t       state;
    arb_state_t       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             last;
    logic             pick;
    logic             pick_vld;

    // last always equals the current owner while in OWNn, so one picker
    // serves both the idle choice and the burst-limit re-arbitration.
    arb_pick u_pick (
        .req0  (req0),
        .req1  (req1),
        .last  (last),
        .fixed (FIXED),
        .pick  (pick),
        .valid (pick_vld)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (pick_vld) begin
                    state_nxt = pick ? ST_OWN1 : ST_OWN0;
                end
            end
            ST_OWN0: begin
                if (!req0) begin
                    state_nxt = req1 ? ST_OWN1 : ST_IDLE;
                end else if (req1 && cnt == CNT_LAST) begin
                    state_nxt = pick ? ST_OWN1 : ST_OWN0;
                end
            end
            ST_OWN1: begin
                if (!req1) begin
                    state_nxt = req0 ? ST_OWN0 : ST_IDLE;
                end else if (req0 && cnt == CNT_LAST) begin
                    state_nxt = pick ? ST_OWN1 : ST_OWN0;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        gnt0      = (state == ST_OWN0);
        gnt1      = (state == ST_OWN1);
        address   = '0;
        to_memory = '0;
        write     = 1'b0;
        case (state)
            ST_OWN0: begin
                address   = addr0;
                to_memory = wdata0;
                write     = write0 & req0;
            end
            ST_OWN1: begin
                address   = addr1;
                to_memory = wdata1;
                write     = write1 & req1;
            end
            default: ;
        endcase
    end

    // Count saturates at the limit so a late request from the other port
    // takes the bus at the very next edge.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cnt  <= '0;
            last <= 1'b1;
        end else begin
            if (state_nxt != state || state_nxt == ST_IDLE) begin
                cnt <= '0;
            end else if (cnt != CNT_LAST) begin
                cnt <= cnt + 1'b1;
            end
            if (state_nxt == ST_OWN0 && state != ST_OWN0) begin
                last <= 1'b0;
            end else if (state_nxt == ST_OWN1 && state != ST_OWN1) begin
                last <= 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
        end else begin
            rvalid0 <= (state == ST_OWN0) & req0 & ~write0;
            rvalid1 <= (state == ST_OWN1) & req1 & ~write1;
        end
    end

    assign rdata0 = from_memory;
    assign rdata1 = from_memory;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a round-robin and a fixed-priority instance share one
// stimulus stream and are each checked against an owner/beat-count reference model.
module tb_mem_arbiter;

    localparam int BM = 4;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       mem_clr;
    logic       req0, req1, write0, write1;
    logic [7:0] addr0, addr1, wdata0, wdata1;

    logic       rr_gnt0, rr_gnt1, rr_rvalid0, rr_rvalid1, rr_write;
    logic [7:0] rr_rdata0, rr_rdata1, rr_address, rr_to_memory, rr_from_memory;
    logic       fx_gnt0, fx_gnt1, fx_rvalid0, fx_rvalid1, fx_write;
    logic [7:0] fx_rdata0, fx_rdata1, fx_address, fx_to_memory, fx_from_memory;

    logic [7:0] rr_mem [256];
    logic [7:0] fx_mem [256];

    int total = 0;
    int bad   = 0;

    // Reference model state, index 0 = round-robin DUT, 1 = fixed-priority DUT.
    int         own   [2];
    int         beats [2];
    int         last  [2];
    logic       ev0   [2];
    logic       ev1   [2];
    logic [7:0] erd   [2];
    logic [7:0] ref_mem [2][256];

    always #5 Clk = ~Clk;

    mem_arbiter #(.ADDR_W(8), .DATA_W(8), .BURST_MAX(BM), .FIXED_PRIORITY(0)) u_rr (
        .Clk(Clk), .Reset(Reset),
        .req0(req0), .req1(req1), .write0(write0), .write1(write1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(rr_gnt0), .gnt1(rr_gnt1), .rdata0(rr_rdata0), .rdata1(rr_rdata1),
        .rvalid0(rr_rvalid0), .rvalid1(rr_rvalid1),
        .address(rr_address), .to_memory(rr_to_memory), .write(rr_write),
        .from_memory(rr_from_memory)
    );

    mem_arbiter #(.ADDR_W(8), .DATA_W(8), .BURST_MAX(BM), .FIXED_PRIORITY(1)) u_fx (
        .Clk(Clk), .Reset(Reset),
        .req0(req0), .req1(req1), .write0(write0), .write1(write1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(fx_gnt0), .gnt1(fx_gnt1), .rdata0(fx_rdata0), .rdata1(fx_rdata1),
        .rvalid0(fx_rvalid0), .rvalid1(fx_rvalid1),
        .address(fx_address), .to_memory(fx_to_memory), .write(fx_write),
        .from_memory(fx_from_memory)
    );

    // Synchronous memories with one-cycle read latency.
    always @(posedge Clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) begin
                rr_mem[i] <= 8'h00;
                fx_mem[i] <= 8'h00;
            end
        end else begin
            if (rr_write) rr_mem[rr_address] <= rr_to_memory;
            if (fx_write) fx_mem[fx_address] <= fx_to_memory;
        end
        rr_from_memory <= rr_mem[rr_address];
        fx_from_memory <= fx_mem[fx_address];
    end

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            own[k]   = -1;
            beats[k] = 0;
            last[k]  = 1;
            ev0[k]   = 1'b0;
            ev1[k]   = 1'b0;
            erd[k]   = 8'h00;
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            int   nxt;
            logic mine;
            logic other;
            ev0[k] = (own[k] == 0) && req0 && !write0;
            ev1[k] = (own[k] == 1) && req1 && !write1;
            if (ev0[k]) erd[k] = ref_mem[k][addr0];
            if (ev1[k]) erd[k] = ref_mem[k][addr1];
            if (own[k] == 0 && req0 && write0) ref_mem[k][addr0] = wdata0;
            if (own[k] == 1 && req1 && write1) ref_mem[k][addr1] = wdata1;
            nxt = own[k];
            if (own[k] < 0) begin
                if (req0 && req1) nxt = (k == 1) ? 0 : 1 - last[k];
                else if (req0)    nxt = 0;
                else if (req1)    nxt = 1;
            end else begin
                mine  = (own[k] == 0) ? req0 : req1;
                other = (own[k] == 0) ? req1 : req0;
                if (!mine)                          nxt = other ? 1 - own[k] : -1;
                else if (other && beats[k] >= BM)   nxt = (k == 1) ? 0 : 1 - own[k];
            end
            if (nxt != own[k]) begin
                own[k]   = nxt;
                beats[k] = (nxt >= 0) ? 1 : 0;
                if (nxt >= 0) last[k] = nxt;
            end else if (own[k] >= 0) begin
                beats[k]++;
            end
        end
    endtask

    task automatic check_outputs();
        for (int k = 0; k < 2; k++) begin
            string      pfx = (k == 0) ? "rr_" : "fx_";
            logic [7:0] ea = 8'h00;
            logic [7:0] ed = 8'h00;
            logic       ew = 1'b0;
            if (own[k] == 0) begin
                ea = addr0; ed = wdata0; ew = req0 & write0;
            end else if (own[k] == 1) begin
                ea = addr1; ed = wdata1; ew = req1 & write1;
            end
            chk({pfx, "gnt0"},    8'(k == 0 ? rr_gnt0 : fx_gnt0),       8'(own[k] == 0));
            chk({pfx, "gnt1"},    8'(k == 0 ? rr_gnt1 : fx_gnt1),       8'(own[k] == 1));
            chk({pfx, "address"}, (k == 0) ? rr_address : fx_address,     ea);
            chk({pfx, "to_mem"},  (k == 0) ? rr_to_memory : fx_to_memory, ed);
            chk({pfx, "write"},   8'(k == 0 ? rr_write : fx_write),     8'(ew));
            chk({pfx, "rvalid0"}, 8'(k == 0 ? rr_rvalid0 : fx_rvalid0), 8'(ev0[k]));
            chk({pfx, "rvalid1"}, 8'(k == 0 ? rr_rvalid1 : fx_rvalid1), 8'(ev1[k]));
            if (ev0[k]) chk({pfx, "rdata0"}, (k == 0) ? rr_rdata0 : fx_rdata0, erd[k]);
            if (ev1[k]) chk({pfx, "rdata1"}, (k == 0) ? rr_rdata1 : fx_rdata1, erd[k]);
        end
    endtask

    task automatic check_in_reset(input string tag);
        chk({tag, "_rr_gnt0"},   8'(rr_gnt0),    8'h00);
        chk({tag, "_rr_gnt1"},   8'(rr_gnt1),    8'h00);
        chk({tag, "_rr_rvalid1"}, 8'(rr_rvalid1), 8'h00);
        chk({tag, "_fx_gnt0"},   8'(fx_gnt0),    8'h00);
        chk({tag, "_fx_gnt1"},   8'(fx_gnt1),    8'h00);
        chk({tag, "_fx_rvalid1"}, 8'(fx_rvalid1), 8'h00);
    endtask

    task automatic cycle(input logic r0, input logic w0, input logic [7:0] a0, input logic [7:0] d0,
                         input logic r1, input logic w1, input logic [7:0] a1, input logic [7:0] d1);
        req0 = r0; write0 = w0; addr0 = a0; wdata0 = d0;
        req1 = r1; write1 = w1; addr1 = a1; wdata1 = d1;
        #1;
        check_outputs();
        @(posedge Clk);
        model_step();
        @(negedge Clk);
    endtask

    initial begin
        logic r0 = 1'b0;
        logic r1 = 1'b0;

        for (int i = 0; i < 256; i++) begin
            ref_mem[0][i] = 8'h00;
            ref_mem[1][i] = 8'h00;
        end
        Reset   = 1'b1;
        mem_clr = 1'b1;
        req0 = 1'b1; write0 = 1'b0; addr0 = 8'h11; wdata0 = 8'h00;
        req1 = 1'b0; write1 = 1'b0; addr1 = 8'h00; wdata1 = 8'h00;
        model_reset();

        // Reset held with req0 high: no grant until release, then one cycle of latency.
        @(negedge Clk);
        @(negedge Clk);
        #1;
        check_in_reset("rst_hold");
        mem_clr = 1'b0;
        Reset   = 1'b0;
        cycle(1, 0, 8'h11, 8'h00, 0, 0, 8'h00, 8'h00);
        chk("rel_rr_gnt0", 8'(rr_gnt0), 8'h01);
        chk("rel_rr_addr", rr_address, 8'h11);
        cycle(1, 0, 8'h11, 8'h00, 0, 0, 8'h00, 8'h00);
        cycle(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
        cycle(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);

        // Both requesting from reset: RR alternates every BM beats, fixed keeps port 0.
        Reset = 1'b1;
        model_reset();
        @(negedge Clk);
        Reset = 1'b0;
        for (int i = 0; i < 20; i++) cycle(1, 0, 8'h40, 8'h00, 1, 0, 8'h41, 8'h00);
        chk("fx_hold_gnt0", 8'(fx_gnt0), 8'h01);
        for (int i = 0; i < 3; i++) cycle(0, 0, 8'h40, 8'h00, 1, 0, 8'h41, 8'h00);
        chk("fx_after_gnt1", 8'(fx_gnt1), 8'h01);
        cycle(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
        cycle(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);

        // Port 1 writes A5 to 0x20, then port 0 reads it back.
        cycle(0, 0, 8'h00, 8'h00, 1, 1, 8'h20, 8'hA5);
        cycle(0, 0, 8'h00, 8'h00, 1, 1, 8'h20, 8'hA5);
        cycle(1, 0, 8'h20, 8'h00, 0, 0, 8'h00, 8'h00);
        cycle(1, 0, 8'h20, 8'h00, 0, 0, 8'h00, 8'h00);
        #1;
        chk("rd_rr_rvalid0", 8'(rr_rvalid0), 8'h01);
        chk("rd_rr_rdata0",  rr_rdata0, 8'hA5);
        chk("rd_rr_rvalid1", 8'(rr_rvalid1), 8'h00);
        @(negedge Clk);
        cycle(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);

        // Port 1 holds a write while port 0 keeps the fixed-priority bus.
        for (int i = 0; i < 8; i++) cycle(1, 0, 8'h31, 8'h00, 1, 1, 8'h30, 8'h5A);
        cycle(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
        cycle(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
        chk("fx_nowrite_mem", fx_mem[8'h30], 8'h00);
        chk("rr_write_mem",   rr_mem[8'h30], ref_mem[0][8'h30]);

        // Asynchronous reset in the middle of an OWN1 read burst.
        for (int i = 0; i < 3; i++) cycle(0, 0, 8'h00, 8'h00, 1, 0, 8'h20, 8'h00);
        #1;
        chk("pre_rst_rr_rvalid1", 8'(rr_rvalid1), 8'h01);
        Reset = 1'b1;
        #1;
        check_in_reset("rst_async");
        model_reset();
        req0 = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        cycle(1, 0, 8'h22, 8'h00, 1, 0, 8'h23, 8'h00);
        chk("post_rst_rr_gnt0", 8'(rr_gnt0), 8'h01);
        for (int i = 0; i < 6; i++) cycle(1, 0, 8'h22, 8'h00, 1, 0, 8'h23, 8'h00);

        // Randomised traffic over a small address window.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(3) == 0) r0 = ~r0;
            if ($urandom_range(3) == 0) r1 = ~r1;
            cycle(r0, 1'($urandom_range(1)), 8'($urandom_range(15)), 8'($urandom),
                  r1, 1'($urandom_range(1)), 8'($urandom_range(15)), 8'($urandom));
        end
        for (int i = 0; i < 16; i++) begin
            chk("final_rr_mem", rr_mem[i], ref_mem[0][i]);
            chk("final_fx_mem", fx_mem[i], ref_mem[1][i]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
